// File: rtl/lsu_pkg.sv
// Shared definitions for the load/store unit: funct3 access encodings,
// access-size decode helpers and FSM state encoding.
package lsu_pkg;

   localparam logic [2:0] F3_B  = 3'b000;
   localparam logic [2:0] F3_H  = 3'b001;
   localparam logic [2:0] F3_W  = 3'b010;
   localparam logic [2:0] F3_BU = 3'b100;
   localparam logic [2:0] F3_HU = 3'b101;

   localparam logic [1:0] ST_IDLE  = 2'd0;
   localparam logic [1:0] ST_BEAT0 = 2'd1;
   localparam logic [1:0] ST_BEAT1 = 2'd2;
   localparam logic [1:0] ST_RESP  = 2'd3;

   typedef struct packed {
      logic        we;
      logic [2:0]  funct3;
      logic [1:0]  off;
      logic [31:0] wdata;
   } lsu_req_t;

   function automatic logic [2:0] access_size(input logic [2:0] funct3);
      case (funct3[1:0])
         2'b00:   access_size = 3'd1;
         2'b01:   access_size = 3'd2;
         default: access_size = 3'd4;
      endcase
   endfunction

   function automatic logic [3:0] lane_mask(input logic [2:0] funct3);
      case (funct3[1:0])
         2'b00:   lane_mask = 4'b0001;
         2'b01:   lane_mask = 4'b0011;
         default: lane_mask = 4'b1111;
      endcase
   endfunction

   // Unsigned variants only make sense for loads.
   function automatic logic funct3_legal(input logic [2:0] funct3, input logic we);
      case (funct3)
         F3_B, F3_H, F3_W: funct3_legal = 1'b1;
         F3_BU, F3_HU:     funct3_legal = ~we;
         default:          funct3_legal = 1'b0;
      endcase
   endfunction

   function automatic logic is_split(input logic [1:0] off, input logic [2:0] funct3);
      is_split = ({2'b00, off} + {1'b0, access_size(funct3)}) > 4'd4;
   endfunction

endpackage

// File: rtl/load_extend.sv
// Aligns a possibly word-straddling load from its two raw memory words,
// truncates it to the access size and sign- or zero-extends it.
module load_extend
   import lsu_pkg::*;
(
   input  logic [31:0] low_word,
   input  logic [31:0] high_word,
   input  logic [1:0]  off,
   input  logic [2:0]  funct3,
   output logic [31:0] data
);

   logic [31:0] aligned;

   assign aligned = 32'({high_word, low_word} >> {off, 3'b000});

   always_comb begin
      data = aligned;
      case (funct3)
         F3_B:    data = {{24{aligned[7]}}, aligned[7:0]};
         F3_H:    data = {{16{aligned[15]}}, aligned[15:0]};
         F3_BU:   data = {24'd0, aligned[7:0]};
         F3_HU:   data = {16'd0, aligned[15:0]};
         default: data = aligned;
      endcase
   end

endmodule

// File: rtl/load_store_unit.sv
// Byte/half/word load-store unit in front of a word-wide memory; misaligned
// accesses that straddle a word boundary are issued as two memory beats.
module load_store_unit
   import lsu_pkg::*;
#(
   parameter int ADDR_WIDTH = 15,
   parameter int DATA_WIDTH = 32
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  req_valid,
   output logic                  req_ready,
   input  logic                  req_we,
   input  logic [2:0]            req_funct3,
   input  logic [31:0]           req_addr,
   input  logic [31:0]           req_wdata,
   output logic                  resp_valid,
   output logic [31:0]           resp_rdata,
   output logic                  resp_err,
   output logic                  mem_we,
   output logic [3:0]            mem_be,
   output logic [2:0]            mem_op_read,
   output logic [ADDR_WIDTH-1:0] mem_addr,
   output logic [DATA_WIDTH-1:0] mem_wdata,
   input  logic [DATA_WIDTH-1:0] mem_rdata
);

   logic [1:0]            state_reg, state_next;
   lsu_req_t              req_reg;
   logic [ADDR_WIDTH-1:0] word_reg;
   logic [31:0]           low_reg, high_reg;
   logic                  err_reg;
   logic                  req_legal, req_split;
   logic [7:0]            be_span;
   logic [63:0]           wdata_span;
   logic [31:0]           load_data;
   logic                  unused_addr;

   // Byte address bits above the attached memory are ignored.
   assign unused_addr = ^req_addr[31:ADDR_WIDTH+2];

   assign req_legal  = funct3_legal(req_funct3, req_we);
   assign req_split  = is_split(req_reg.off, req_reg.funct3);
   // Two-word windows: low half drives beat 0, high half spills into beat 1.
   assign be_span    = {4'b0000, lane_mask(req_reg.funct3)} << req_reg.off;
   assign wdata_span = {32'd0, req_reg.wdata} << {req_reg.off, 3'b000};

   always_comb begin
      state_next = state_reg;
      case (state_reg)
         ST_IDLE:  if (req_valid) state_next = req_legal ? ST_BEAT0 : ST_RESP;
         ST_BEAT0: state_next = req_split ? ST_BEAT1 : ST_RESP;
         ST_BEAT1: state_next = ST_RESP;
         default:  state_next = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_reg <= ST_IDLE;
         req_reg   <= '0;
         word_reg  <= '0;
         low_reg   <= '0;
         high_reg  <= '0;
         err_reg   <= 1'b0;
      end else begin
         state_reg <= state_next;
         case (state_reg)
            ST_IDLE: begin
               if (req_valid) begin
                  req_reg  <= '{we: req_we, funct3: req_funct3,
                                off: req_addr[1:0], wdata: req_wdata};
                  word_reg <= req_addr[ADDR_WIDTH+1:2];
                  err_reg  <= ~req_legal;
                  low_reg  <= '0;
                  high_reg <= '0;
               end
            end
            ST_BEAT0: if (!req_reg.we) low_reg <= mem_rdata;
            ST_BEAT1: if (!req_reg.we) high_reg <= mem_rdata;
            default: ;
         endcase
      end
   end

   always_comb begin
      mem_we    = 1'b0;
      mem_be    = '0;
      mem_addr  = word_reg;
      mem_wdata = '0;
      case (state_reg)
         ST_BEAT0: begin
            mem_we    = req_reg.we;
            mem_be    = be_span[3:0];
            mem_wdata = wdata_span[31:0];
         end
         ST_BEAT1: begin
            mem_we    = req_reg.we;
            mem_be    = be_span[7:4];
            mem_addr  = word_reg + ADDR_WIDTH'(1);
            mem_wdata = wdata_span[63:32];
         end
         default: ;
      endcase
      // A reset arriving mid-access must not let the pending beat land.
      if (rst) mem_we = 1'b0;
   end

   load_extend u_load_extend (
      .low_word  (low_reg),
      .high_word (high_reg),
      .off       (req_reg.off),
      .funct3    (req_reg.funct3),
      .data      (load_data)
   );

   assign mem_op_read = 3'b010;
   assign req_ready   = (state_reg == ST_IDLE) && !rst;
   assign resp_valid  = (state_reg == ST_RESP) && !rst;
   assign resp_err    = resp_valid && err_reg;
   assign resp_rdata  = (resp_valid && !err_reg && !req_reg.we) ? load_data : '0;

endmodule

// File: tb/tb_load_store_unit.sv
// Self-checking bench for load_store_unit: vector table plus scoreboard
// against a behavioural byte-enabled memory, and a mid-access reset sequence.
module tb_load_store_unit;

   logic        clk = 1'b0;
   logic        rst;
   logic        req_valid, req_ready, req_we;
   logic [2:0]  req_funct3;
   logic [31:0] req_addr, req_wdata;
   logic        resp_valid, resp_err;
   logic [31:0] resp_rdata;
   logic        mem_we;
   logic [3:0]  mem_be;
   logic [2:0]  mem_op_read;
   logic [14:0] mem_addr;
   logic [31:0] mem_wdata, mem_rdata;

   logic [31:0] mem [0:32767];

   int checks   = 0;
   int failures = 0;

   typedef struct {
      logic        we;
      logic [2:0]  f3;
      logic [31:0] addr;
      logic [31:0] wdata;
      logic [31:0] rdata;
      logic        err;
      int          lat;
      int          nb;
      logic [14:0] w0;
      logic [3:0]  be0;
      logic [31:0] wd0;
      logic [14:0] w1;
      logic [3:0]  be1;
      logic [31:0] wd1;
   } vec_t;

   typedef struct {
      logic [31:0] rdata;
      logic        err;
      int          lat;
   } exp_t;

   vec_t vecs[$];
   exp_t sb_q[$];

   always #5 clk = ~clk;

   load_store_unit dut (
      .clk         (clk),
      .rst         (rst),
      .req_valid   (req_valid),
      .req_ready   (req_ready),
      .req_we      (req_we),
      .req_funct3  (req_funct3),
      .req_addr    (req_addr),
      .req_wdata   (req_wdata),
      .resp_valid  (resp_valid),
      .resp_rdata  (resp_rdata),
      .resp_err    (resp_err),
      .mem_we      (mem_we),
      .mem_be      (mem_be),
      .mem_op_read (mem_op_read),
      .mem_addr    (mem_addr),
      .mem_wdata   (mem_wdata),
      .mem_rdata   (mem_rdata)
   );

   assign mem_rdata = mem[mem_addr];

   always @(posedge clk) begin
      if (mem_we) begin
         for (int b = 0; b < 4; b++)
            if (mem_be[b]) mem[mem_addr][8*b +: 8] <= mem_wdata[8*b +: 8];
      end
   end

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=%h required=%h", name, act, exp);
      end
   endtask

   task automatic add(input logic we, input logic [2:0] f3, input logic [31:0] addr,
                      input logic [31:0] wdata, input logic [31:0] rdata, input logic err,
                      input int lat, input int nb, input logic [14:0] w0, input logic [3:0] be0,
                      input logic [31:0] wd0, input logic [14:0] w1, input logic [3:0] be1,
                      input logic [31:0] wd1);
      vecs.push_back('{we, f3, addr, wdata, rdata, err, lat, nb, w0, be0, wd0, w1, be1, wd1});
   endtask

   task automatic run_vec(input vec_t v, input int idx);
      int          lat = 0;
      int          nb  = 0;
      int          wec = 0;
      bit          got = 0;
      logic [14:0] bw [2];
      logic [3:0]  bbe [2];
      logic [31:0] bwd [2];
      exp_t        e;
      logic [31:0] seen_rdata = '0;
      logic        seen_err = 1'b0;
      for (int k = 0; k < 2; k++) begin
         bw[k] = '0; bbe[k] = '0; bwd[k] = '0;
      end
      @(negedge clk);
      chk($sformatf("v%0d_ready_idle", idx), 32'(req_ready), 32'd1);
      req_valid  = 1'b1;
      req_we     = v.we;
      req_funct3 = v.f3;
      req_addr   = v.addr;
      req_wdata  = v.wdata;
      sb_q.push_back('{v.rdata, v.err, v.lat});
      @(posedge clk);
      #1;
      req_valid = 1'b0;
      req_we    = 1'b0;
      req_addr  = '0;
      req_wdata = '0;
      while (!got && lat < 8) begin
         @(negedge clk);
         lat++;
         if (lat == 1) chk($sformatf("v%0d_ready_busy", idx), 32'(req_ready), 32'd0);
         if (mem_we) wec++;
         if (mem_be != 4'b0000) begin
            if (nb < 2) begin
               bw[nb] = mem_addr; bbe[nb] = mem_be; bwd[nb] = mem_wdata;
            end
            nb++;
         end
         if (resp_valid) begin
            got = 1;
            seen_rdata = resp_rdata;
            seen_err = resp_err;
            if (sb_q.size() == 0) begin
               chk($sformatf("v%0d_spurious_resp", idx), 32'd1, 32'd0);
            end else begin
               e = sb_q.pop_front();
               chk($sformatf("v%0d_rdata", idx), resp_rdata, e.rdata);
               chk($sformatf("v%0d_err", idx), 32'(resp_err), 32'(e.err));
               chk($sformatf("v%0d_latency", idx), 32'(lat), 32'(e.lat));
            end
         end
      end
      if (!got) begin
         chk($sformatf("v%0d_resp_timeout", idx), 32'(lat), 32'(v.lat));
         sb_q.delete();
      end
      chk($sformatf("v%0d_nbeats", idx), 32'(nb), 32'(v.nb));
      chk($sformatf("v%0d_we_cycles", idx), 32'(wec), v.we ? 32'(v.nb) : 32'd0);
      if (nb >= 1 && v.nb >= 1) begin
         chk($sformatf("v%0d_beat0_word", idx), 32'(bw[0]), 32'(v.w0));
         chk($sformatf("v%0d_beat0_be", idx), 32'(bbe[0]), 32'(v.be0));
         if (v.we) chk($sformatf("v%0d_beat0_wdata", idx), bwd[0], v.wd0);
      end
      if (nb >= 2 && v.nb >= 2) begin
         chk($sformatf("v%0d_beat1_word", idx), 32'(bw[1]), 32'(v.w1));
         chk($sformatf("v%0d_beat1_be", idx), 32'(bbe[1]), 32'(v.be1));
         if (v.we) chk($sformatf("v%0d_beat1_wdata", idx), bwd[1], v.wd1);
      end
      $display("txn %0d we=%0d f3=%b addr=%h wdata=%h -> rdata=%h err=%0d lat=%0d beats=%0d",
               idx, v.we, v.f3, v.addr, v.wdata, seen_rdata, seen_err, lat, nb);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog actual=timeout required=finish");
      $fatal(1, "watchdog expired");
   end

   initial begin
      int n_we;
      int n_rsp;
      for (int i = 0; i < 32768; i++) mem[i] = '0;
      rst = 1'b1; req_valid = 1'b0; req_we = 1'b0; req_funct3 = '0;
      req_addr = '0; req_wdata = '0;

      //  we f3      addr           wdata          rdata          err lat nb w0        be0      wd0            w1     be1      wd1
      add(1, 3'b010, 32'h10,        32'hDEADBEEF,  32'h0,         0,  2,  1, 15'h4,    4'b1111, 32'hDEADBEEF,  15'h0, 4'b0000, 32'h0);
      add(0, 3'b010, 32'h10,        32'h0,         32'hDEADBEEF,  0,  2,  1, 15'h4,    4'b1111, 32'h0,         15'h0, 4'b0000, 32'h0);
      add(1, 3'b010, 32'h10,        32'h80FF7F01,  32'h0,         0,  2,  1, 15'h4,    4'b1111, 32'h80FF7F01,  15'h0, 4'b0000, 32'h0);
      add(0, 3'b000, 32'h11,        32'h0,         32'h0000007F,  0,  2,  1, 15'h4,    4'b0010, 32'h0,         15'h0, 4'b0000, 32'h0);
      add(0, 3'b000, 32'h12,        32'h0,         32'hFFFFFFFF,  0,  2,  1, 15'h4,    4'b0100, 32'h0,         15'h0, 4'b0000, 32'h0);
      add(0, 3'b100, 32'h13,        32'h0,         32'h00000080,  0,  2,  1, 15'h4,    4'b1000, 32'h0,         15'h0, 4'b0000, 32'h0);
      add(0, 3'b001, 32'h12,        32'h0,         32'hFFFF80FF,  0,  2,  1, 15'h4,    4'b1100, 32'h0,         15'h0, 4'b0000, 32'h0);
      add(0, 3'b101, 32'h12,        32'h0,         32'h000080FF,  0,  2,  1, 15'h4,    4'b1100, 32'h0,         15'h0, 4'b0000, 32'h0);
      add(0, 3'b001, 32'h10,        32'h0,         32'h00007F01,  0,  2,  1, 15'h4,    4'b0011, 32'h0,         15'h0, 4'b0000, 32'h0);
      add(0, 3'b000, 32'h13,        32'h0,         32'hFFFFFF80,  0,  2,  1, 15'h4,    4'b1000, 32'h0,         15'h0, 4'b0000, 32'h0);
      add(1, 3'b010, 32'h13,        32'h11223344,  32'h0,         0,  3,  2, 15'h4,    4'b1000, 32'h44000000,  15'h5, 4'b0111, 32'h00112233);
      add(0, 3'b010, 32'h13,        32'h0,         32'h11223344,  0,  3,  2, 15'h4,    4'b1000, 32'h0,         15'h5, 4'b0111, 32'h0);
      add(1, 3'b001, 32'h0001FFFF,  32'h0000ABCD,  32'h0,         0,  3,  2, 15'h7FFF, 4'b1000, 32'hCD000000,  15'h0, 4'b0001, 32'h000000AB);
      add(0, 3'b101, 32'h0001FFFF,  32'h0,         32'h0000ABCD,  0,  3,  2, 15'h7FFF, 4'b1000, 32'h0,         15'h0, 4'b0001, 32'h0);
      add(0, 3'b001, 32'h0001FFFF,  32'h0,         32'hFFFFABCD,  0,  3,  2, 15'h7FFF, 4'b1000, 32'h0,         15'h0, 4'b0001, 32'h0);
      add(1, 3'b000, 32'h21,        32'hFFFFFFA5,  32'h0,         0,  2,  1, 15'h8,    4'b0010, 32'hFFFFA500,  15'h0, 4'b0000, 32'h0);
      add(1, 3'b001, 32'h22,        32'h00001234,  32'h0,         0,  2,  1, 15'h8,    4'b1100, 32'h12340000,  15'h0, 4'b0000, 32'h0);
      add(0, 3'b010, 32'h20,        32'h0,         32'h1234A500,  0,  2,  1, 15'h8,    4'b1111, 32'h0,         15'h0, 4'b0000, 32'h0);
      add(0, 3'b011, 32'h10,        32'h0,         32'h0,         1,  1,  0, 15'h0,    4'b0000, 32'h0,         15'h0, 4'b0000, 32'h0);
      add(1, 3'b100, 32'h10,        32'hFFFFFFFF,  32'h0,         1,  1,  0, 15'h0,    4'b0000, 32'h0,         15'h0, 4'b0000, 32'h0);
      add(0, 3'b111, 32'h13,        32'h0,         32'h0,         1,  1,  0, 15'h0,    4'b0000, 32'h0,         15'h0, 4'b0000, 32'h0);
      add(1, 3'b101, 32'h10,        32'h12345678,  32'h0,         1,  1,  0, 15'h0,    4'b0000, 32'h0,         15'h0, 4'b0000, 32'h0);
      add(0, 3'b010, 32'h10,        32'h0,         32'h44FF7F01,  0,  2,  1, 15'h4,    4'b1111, 32'h0,         15'h0, 4'b0000, 32'h0);
      add(0, 3'b010, 32'h00080010,  32'h0,         32'h44FF7F01,  0,  2,  1, 15'h4,    4'b1111, 32'h0,         15'h0, 4'b0000, 32'h0);

      repeat (2) @(posedge clk);
      @(negedge clk);
      chk("rst_mem_we", 32'(mem_we), 32'd0);
      chk("rst_resp_valid", 32'(resp_valid), 32'd0);
      @(negedge clk);
      rst = 1'b0;
      #1;
      chk("reset_ready", 32'(req_ready), 32'd1);
      chk("reset_resp_valid", 32'(resp_valid), 32'd0);
      chk("reset_resp_err", 32'(resp_err), 32'd0);
      chk("reset_resp_rdata", resp_rdata, 32'd0);
      chk("reset_mem_be", 32'(mem_be), 32'd0);
      chk("mem_op_read", 32'(mem_op_read), 32'b010);

      for (int i = 0; i < vecs.size(); i++) run_vec(vecs[i], i);

      // Reset lands during beat 0 of a split store: neither beat may write.
      @(negedge clk);
      chk("rst_seq_ready", 32'(req_ready), 32'd1);
      req_valid = 1'b1; req_we = 1'b1; req_funct3 = 3'b010;
      req_addr = 32'h13; req_wdata = 32'h55667788;
      @(posedge clk);
      #1;
      req_valid = 1'b0; req_we = 1'b0; req_addr = '0; req_wdata = '0;
      @(negedge clk);
      chk("rst_seq_beat0_be", 32'(mem_be), 32'(4'b1000));
      rst = 1'b1;
      #1;
      chk("rst_seq_we_forced", 32'(mem_we), 32'd0);
      @(negedge clk);
      rst = 1'b0;
      #1;
      chk("rst_seq_ready_after", 32'(req_ready), 32'd1);
      n_we = 0;
      n_rsp = 0;
      repeat (5) begin
         @(negedge clk);
         if (mem_we) n_we++;
         if (resp_valid) n_rsp++;
      end
      chk("rst_seq_no_we", 32'(n_we), 32'd0);
      chk("rst_seq_no_resp", 32'(n_rsp), 32'd0);
      chk("rst_seq_word4", mem[4], 32'h44FF7F01);
      chk("rst_seq_word5", mem[5], 32'h00112233);
      $display("txn rst_seq we=1 f3=010 addr=00000013 wdata=55667788 -> abandoned we_cycles=%0d resp=%0d",
               n_we, n_rsp);

      run_vec('{1'b0, 3'b010, 32'h13, 32'h0, 32'h11223344, 1'b0, 3, 2,
                15'h4, 4'b1000, 32'h0, 15'h5, 4'b0111, 32'h0}, vecs.size());

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
